// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg : segment glyph constants and BCD-to-segment decode
// Rev 1.0
// ============================================================================
package seg7_pkg;

    // Active-low segments ordered {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_tick_div.sv
`default_nettype none
// ============================================================================
// seg7_tick_div : free-running 0..DIV-1 counter with a terminal-count tick
// Rev 1.0
// ============================================================================
module seg7_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tc;

    assign tc   = (cnt_q == CW'(DIV - 1));
    assign tick = tc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr || tc) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver : 4-digit multiplexed 7-segment scan with dead time,
//                    per-digit blink, leading-zero blanking and error glyph
// Rev 1.0
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000,
    parameter int DEAD_CYC  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       disp_en,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic [3:0] blink_mask,
    input  logic       blank_lz,
    output logic [3:0] Anode_Activate,
    output logic [6:0] LED_out
);

    localparam int DW = $clog2(DEAD_CYC + 2);

    logic          scan_tick;
    logic          blink_tick;
    logic          mask_chg;
    logic [1:0]    idx_q;
    logic          blink_on_q;
    logic [3:0]    mask_q;
    logic [DW-1:0] dead_cnt_q;
    logic          dead;
    logic [3:0]    lz_blank;
    logic [3:0]    cur_digit;
    logic          show;
    logic [3:0]    an_d;
    logic [6:0]    led_d;
    logic [3:0]    an_q;
    logic [6:0]    led_q;

    assign mask_chg = (blink_mask != mask_q);

    seg7_tick_div #(.DIV(SCAN_DIV)) u_scan_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .tick (scan_tick)
    );

    seg7_tick_div #(.DIV(BLINK_DIV)) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (mask_chg),
        .tick (blink_tick)
    );

    // Tracks the first DEAD_CYC counts of each slot in lockstep with the scan prescaler
    assign dead = (dead_cnt_q < DW'(DEAD_CYC));

    // A non-BCD digit is non-zero, so it always breaks the leading-zero run
    assign lz_blank[0] = blank_lz && (digit1 == 4'd0);
    assign lz_blank[1] = blank_lz && (digit1 == 4'd0) && (digit2 == 4'd0);
    assign lz_blank[2] = blank_lz && (digit1 == 4'd0) && (digit2 == 4'd0) && (digit3 == 4'd0);
    assign lz_blank[3] = 1'b0;

    always_comb begin
        cur_digit = digit1;
        case (idx_q)
            2'd0:    cur_digit = digit1;
            2'd1:    cur_digit = digit2;
            2'd2:    cur_digit = digit3;
            default: cur_digit = digit4;
        endcase
    end

    assign show  = disp_en && !lz_blank[idx_q] && !(blink_mask[idx_q] && !blink_on_q);
    assign led_d = show ? bcd_to_seg(cur_digit) : SEG_BLANK;
    assign an_d  = (show && !dead) ? ~(4'b0001 << idx_q) : 4'b1111;

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q      <= 2'd0;
            blink_on_q <= 1'b1;
            mask_q     <= 4'd0;
            dead_cnt_q <= '0;
            an_q       <= 4'b1111;
            led_q      <= SEG_BLANK;
        end else begin
            an_q   <= an_d;
            led_q  <= led_d;
            mask_q <= blink_mask;
            if (scan_tick) begin
                idx_q      <= idx_q + 2'd1;
                dead_cnt_q <= '0;
            end else if (dead) begin
                dead_cnt_q <= dead_cnt_q + DW'(1);
            end
            // A freshly selected field restarts in the visible phase
            if (mask_chg) begin
                blink_on_q <= 1'b1;
            end else if (blink_tick) begin
                blink_on_q <= ~blink_on_q;
            end
        end
    end

    assign Anode_Activate = an_q;
    assign LED_out        = led_q;

endmodule
`default_nettype wire
